// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Two-to-one arbiter that lets the I-cache and D-cache miss ports share one
//   slow memory port. An access is never split: once a side is granted it owns
//   the memory port until mem_ready_i. After every completed access there is
//   one GAP cycle with mem_read_o/mem_write_o low, so the memory never sees the
//   previous request still asserted and takes it for a new one.
//
//   Arbitration on a tie: round-robin against the last granted side (after
//   reset D wins the first tie). Defining the macro FIXED_PRIO_EN makes every
//   tie go to D instead.
//
//   A watchdog counts BUSY cycles without mem_ready_i and sets the sticky
//   err_timeout_o when the count reaches TIMEOUT_CYC (0 disables it). The FSM
//   is not released by a timeout; only rst_i recovers it.
//
// Parameters
//   ADDR_W       line-address width
//   DATA_W       line width in bits
//   TIMEOUT_CYC  watchdog limit in cycles, 0 = off (max 1023)
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   i_read_i/i_write_i/i_addr_i/i_wdata_i   I-cache request (held until ready)
//   i_rdata_o, i_ready_o            I-cache read data and completion pulse
//   d_*                             same for the D-cache side
//   mem_read_o/mem_write_o/mem_addr_o/mem_wdata_o   to slow memory
//   mem_rdata_i, mem_ready_i        from slow memory (ready: 1-cycle pulse)
//   err_timeout_o                   sticky watchdog flag
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_read_i,
    input  logic              i_write_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [DATA_W-1:0] i_wdata_i,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_ready_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        GAP    = 2'd3
    } state_e;

    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT_CYC);

    state_e     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;   // 0 = I, 1 = D
    logic [9:0] wd_cnt_q, wd_cnt_d;
    logic       err_q, err_d;

    logic i_req, d_req, tie_to_d, grant_d, busy;

    assign i_req = i_read_i | i_write_i;
    assign d_req = d_read_i | d_write_i;
    assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);

`ifdef FIXED_PRIO_EN
    // D-cache misses stall the pipe longer, so D always wins a tie.
    // last_gnt is still tracked but plays no part in the choice.
    assign tie_to_d = 1'b1;
`else
    // Round-robin: on a tie the side that was not served last wins.
    assign tie_to_d = ~last_gnt_q;
`endif

    assign grant_d = d_req & (~i_req | tie_to_d);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            wd_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE, GAP: begin
                if (i_req || d_req) state_d = grant_d ? BUSY_D : BUSY_I;
                else                state_d = IDLE;
            end
            BUSY_I: begin
                if (mem_ready_i) begin
                    state_d    = GAP;
                    last_gnt_d = 1'b0;
                end
            end
            BUSY_D: begin
                if (mem_ready_i) begin
                    state_d    = GAP;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog: the count is held at zero outside BUSY, which gives the
    // clear-on-entry behaviour. It saturates so it can never wrap back
    // below the limit.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        err_d    = err_q;
        if (!busy) begin
            wd_cnt_d = '0;
        end else if (!mem_ready_i && (wd_cnt_q != 10'h3FF)) begin
            wd_cnt_d = wd_cnt_q + 10'd1;
        end
        if ((TIMEOUT_CYC != 0) && busy && !mem_ready_i && (wd_cnt_d == WD_LIMIT))
            err_d = 1'b1;
    end

    // Output logic
    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        i_ready_o   = 1'b0;
        d_ready_o   = 1'b0;
        case (state_q)
            BUSY_I: begin
                mem_read_o  = i_read_i;
                mem_write_o = i_write_i;
                mem_addr_o  = i_addr_i;
                mem_wdata_o = i_wdata_i;
                i_ready_o   = mem_ready_i;
            end
            BUSY_D: begin
                mem_read_o  = d_read_i;
                mem_write_o = d_write_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
                d_ready_o   = mem_ready_i;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; the caches qualify it with their ready.
    assign i_rdata_o     = mem_rdata_i;
    assign d_rdata_o     = mem_rdata_i;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd [2];
    logic          wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready, err;
    logic [AW-1:0] mem_addr;

    bit req_en, model_en, mem_auto;
    bit done [2];
    int cyc = 0;
    int n_chk = 0, n_pass = 0;

    typedef struct {
        int            side;
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        int            start;
    } exp_t;
    exp_t exp_q[$];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_read_i(rd[0]), .i_write_i(wr[0]), .i_addr_i(ad[0]), .i_wdata_i(wd[0]),
        .i_rdata_o(i_rdata), .i_ready_o(i_ready),
        .d_read_i(rd[1]), .d_write_i(wr[1]), .d_addr_i(ad[1]), .d_wdata_i(wd[1]),
        .d_rdata_o(d_rdata), .d_ready_o(d_ready),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .err_timeout_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Memory model: answers each access after a random 0..5 cycle extra delay.
    task automatic responder();
        int lat, cnt;
        lat = $urandom_range(0, 5);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_auto && (mem_read || mem_write)) begin
                if (cnt >= lat) begin
                    @(posedge clk); #1;
                    mem_ready = 1'b1;
                    mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                    @(posedge clk); #1;
                    mem_ready = 1'b0;
                    cnt = 0;
                    lat = $urandom_range(0, 5);
                end else cnt++;
            end else cnt = 0;
        end
    endtask

    // Cache-side requester: holds a request until its ready, then either
    // re-requests immediately (lands in the GAP cycle) or idles a while.
    task automatic requester(input int s);
        int  idle, to;
        bit  w;
        idle = 0;
        @(posedge clk); #1;
        while (req_en) begin
            if (idle > 0) begin
                rd[s] = 1'b0; wr[s] = 1'b0;
                repeat (idle) @(posedge clk);
                #1;
            end
            w     = ($urandom_range(0, 3) == 0);
            rd[s] = !w;
            wr[s] = w;
            ad[s] = AW'($urandom());
            wd[s] = {$urandom(), $urandom(), $urandom(), $urandom()};
            to = 0;
            do begin
                @(negedge clk);
                to++;
            end while (!(s == 1 ? d_ready : i_ready) && to < 100);
            if (to >= 100) chk(1'b0, "req_timeout", DW'(s), DW'(0));
            @(posedge clk); #1;
            idle = $urandom_range(0, 3);
        end
        rd[s] = 1'b0; wr[s] = 1'b0;
        done[s] = 1'b1;
    endtask

    // Reference model: a single server that, whenever it is free, picks one
    // pending side (tie rule below) and is then occupied until the memory
    // answers. The access must appear on the memory port the next cycle.
    initial begin : model
        int   last, side;
        bit   busy, ip, dp;
        exp_t e;
        last = 0; busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!model_en) begin
                busy = 1'b0; last = 0;
                continue;
            end
            if (busy) begin
                if (mem_ready) begin
                    busy = 1'b0;
                    last = side;
                end
            end else begin
                chk(!mem_read && !mem_write, "quiet_when_free",
                    DW'({mem_read, mem_write}), DW'(0));
                ip = rd[0] || wr[0];
                dp = rd[1] || wr[1];
                if (ip || dp) begin
`ifdef FIXED_PRIO_EN
                    side = dp ? 1 : 0;
`else
                    side = (ip && dp) ? 1 - last : (dp ? 1 : 0);
`endif
                    e.side = side; e.rd = rd[side]; e.wr = wr[side];
                    e.a = ad[side]; e.w = wd[side]; e.start = cyc + 1;
                    exp_q.push_back(e);
                    busy = 1'b1;
                end
            end
        end
    end

    // Monitor: takes the due expectation and checks the memory port and
    // the ready/rdata returned to the caches until the access completes.
    initial begin : monitor
        exp_t cur;
        bit   cur_v;
        logic exp_ir, exp_dr;
        cur_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!model_en) begin
                cur_v = 1'b0;
                continue;
            end
            if (!cur_v && exp_q.size() > 0 && exp_q[0].start <= cyc) begin
                cur   = exp_q.pop_front();
                cur_v = 1'b1;
            end
            if (cur_v) begin
                exp_ir = mem_ready && (cur.side == 0);
                exp_dr = mem_ready && (cur.side == 1);
                chk({mem_read, mem_write, i_ready, d_ready} == {cur.rd, cur.wr, exp_ir, exp_dr},
                    "ctrl", DW'({mem_read, mem_write, i_ready, d_ready}),
                    DW'({cur.rd, cur.wr, exp_ir, exp_dr}));
                chk(mem_addr == cur.a, "mem_addr", DW'(mem_addr), DW'(cur.a));
                chk(mem_wdata == cur.w, "mem_wdata", mem_wdata, cur.w);
                if (mem_ready) begin
                    chk((cur.side == 1 ? d_rdata : i_rdata) == mem_rdata, "rdata",
                        cur.side == 1 ? d_rdata : i_rdata, mem_rdata);
                    cur_v = 1'b0;
                end
            end else if (mem_read || mem_write || i_ready || d_ready) begin
                chk(1'b0, "spurious_access", DW'({mem_read, mem_write, i_ready, d_ready}), DW'(0));
            end
        end
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; ad[s] = '0; wd[s] = '0; done[s] = 1'b0;
        end
        mem_ready = 1'b0; mem_rdata = '0;
        mem_auto = 1'b1; req_en = 1'b0; model_en = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk({mem_read, mem_write, i_ready, d_ready} == 4'b0, "reset_outputs",
            DW'({mem_read, mem_write, i_ready, d_ready}), DW'(0));
        chk(err == 1'b0, "reset_err", DW'(err), DW'(0));

        // Randomized traffic; both sides start in the same cycle after reset
        @(posedge clk); #1;
        rst = 1'b0; model_en = 1'b1; req_en = 1'b1;
        fork
            responder();
            requester(0);
            requester(1);
        join_none
        repeat (800) @(posedge clk);
        req_en = 1'b0;
        for (int k = 0; k < 400 && !(done[0] && done[1]); k++) @(posedge clk);
        if (!(done[0] && done[1])) chk(1'b0, "drain", DW'(0), DW'(1));
        repeat (4) @(posedge clk);
        chk(exp_q.size() == 0, "scoreboard_empty", DW'(exp_q.size()), DW'(0));
        chk(err == 1'b0, "no_timeout_normal", DW'(err), DW'(0));
        #1; model_en = 1'b0; mem_auto = 1'b0;
        repeat (4) @(posedge clk);

        // Watchdog: memory never answers
        #1; rd[1] = 1'b1; ad[1] = AW'(32'h20);
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == TO)     chk(err == 1'b0, "wd_before_limit", DW'(err), DW'(0));
            if (k == TO + 1) chk(err == 1'b1, "wd_fire", DW'(err), DW'(1));
            if (k == 12) begin
                chk(err == 1'b1, "wd_sticky", DW'(err), DW'(1));
                chk(mem_read == 1'b1, "wd_stays_busy", DW'(mem_read), DW'(1));
            end
        end
        @(posedge clk); #1; rst = 1'b1; rd[1] = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk(err == 1'b0, "rst_clears_err", DW'(err), DW'(0));
        chk(mem_read == 1'b0, "rst_idle", DW'(mem_read), DW'(0));

        // D write forwarding, then reset mid-access
        @(posedge clk); #1; wr[1] = 1'b1; wd[1] = {16{8'hA5}}; ad[1] = AW'(32'h20);
        @(negedge clk);
        @(negedge clk);
        chk({mem_read, mem_write} == 2'b01, "dwrite_ctrl", DW'({mem_read, mem_write}), DW'(1));
        chk(mem_wdata == {16{8'hA5}}, "dwrite_wdata", mem_wdata, {16{8'hA5}});
        chk(mem_addr == AW'(32'h20), "dwrite_addr", DW'(mem_addr), DW'(32'h20));
        @(posedge clk); #1; rst = 1'b1; wr[1] = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk({mem_read, mem_write, d_ready} == 3'b0, "rst_mid_busy",
            DW'({mem_read, mem_write, d_ready}), DW'(0));

        // Fresh I read after reset
        @(posedge clk); #1; rd[0] = 1'b1; ad[0] = AW'(32'h10);
        @(negedge clk);
        @(negedge clk);
        chk(mem_read == 1'b1, "i_after_rst_read", DW'(mem_read), DW'(1));
        chk(mem_addr == AW'(32'h10), "i_after_rst_addr", DW'(mem_addr), DW'(32'h10));
        @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = {4{32'hCAFE_0123}};
        @(negedge clk);
        chk({i_ready, d_ready} == 2'b10, "i_ready_pulse", DW'({i_ready, d_ready}), DW'(2));
        chk(i_rdata == {4{32'hCAFE_0123}}, "i_rdata", i_rdata, {4{32'hCAFE_0123}});
        @(posedge clk); #1; mem_ready = 1'b0; rd[0] = 1'b0;
        @(negedge clk);
        chk(mem_read == 1'b0, "gap_after_ready", DW'(mem_read), DW'(0));

        // Stray mem_ready while idle is ignored
        @(posedge clk); #1; mem_ready = 1'b1;
        @(negedge clk);
        chk({mem_read, mem_write, i_ready, d_ready} == 4'b0, "stray_ready",
            DW'({mem_read, mem_write, i_ready, d_ready}), DW'(0));
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        chk(mem_read == 1'b0, "stray_ready_no_state", DW'(mem_read), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
